// File: rtl/ir_nec_pkg.sv
// Shared NEC protocol definitions: FSM state encoding, unit-count constants
// and default timing values in clk27 cycles. ir_rcv uses the same constants
// for its threshold checks.
package ir_nec_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LEAD_MARK  = 4'd1,
        ST_LEAD_SPACE = 4'd2,
        ST_BIT_MARK   = 4'd3,
        ST_BIT_SPACE  = 4'd4,
        ST_STOP_MARK  = 4'd5,
        ST_GAP        = 4'd6,
        ST_REP_MARK   = 4'd7,
        ST_REP_SPACE  = 4'd8,
        ST_REP_STOP   = 4'd9
    } ir_state_e;

    // Durations in 562.5 us NEC units
    localparam logic [4:0] LEAD_MARK_U  = 5'd16;
    localparam logic [4:0] LEAD_SPACE_U = 5'd8;
    localparam logic [4:0] REP_SPACE_U  = 5'd4;
    localparam logic [4:0] ONE_SPACE_U  = 5'd3;
    localparam logic [4:0] BIT_U        = 5'd1;
    localparam logic [7:0] PERIOD_U     = 8'd192;

    // Default clk27 timing
    localparam int unsigned DEF_UNIT_CYCLES = 32'd15188;
    localparam int unsigned DEF_CARR_PERIOD = 32'd711;
    localparam int unsigned DEF_CARR_HIGH   = 32'd237;

    // True for the states in which the LED envelope is on
    function automatic logic is_mark(input ir_state_e st);
        logic mark;
        case (st)
            ST_LEAD_MARK, ST_BIT_MARK, ST_STOP_MARK,
            ST_REP_MARK, ST_REP_STOP: mark = 1'b1;
            default:                  mark = 1'b0;
        endcase
        return mark;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier phase counter. The counter runs only while a mark continues
// and is zero otherwise, so every mark begins at carrier phase 0. carr_nxt is
// the carrier level for the next cycle, letting the parent register ir_tx on
// the same edge as the envelope.
module ir_carrier_gen import ir_nec_pkg::*; #(
    parameter int unsigned CARR_PERIOD = DEF_CARR_PERIOD,
    parameter int unsigned CARR_HIGH   = DEF_CARR_HIGH
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic run,
    output logic carr_nxt
);

    localparam int CW = (CARR_PERIOD > 1) ? $clog2(CARR_PERIOD) : 1;

    logic [CW-1:0] carr_ctr_r;
    logic [CW-1:0] carr_nxt_ctr_s;

    // Next counter value: wrap at the period end, hold at zero when not running
    always_comb begin
        carr_nxt_ctr_s = {CW{1'b0}};
        if (run) begin
            if (carr_ctr_r == CW'(CARR_PERIOD - 1)) begin
                carr_nxt_ctr_s = {CW{1'b0}};
            end else begin
                carr_nxt_ctr_s = carr_ctr_r + CW'(1);
            end
        end else begin
            carr_nxt_ctr_s = {CW{1'b0}};
        end
    end

    // Carrier phase register
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            carr_ctr_r <= {CW{1'b0}};
        end else begin
            carr_ctr_r <= carr_nxt_ctr_s;
        end
    end

    assign carr_nxt = (carr_nxt_ctr_s < CW'(CARR_HIGH));

endmodule

// File: rtl/ir_xmit.sv
// NEC infrared transmitter: sends leader, 32 data bits (LSB first) and a stop
// burst for each accepted code, then NEC repeat frames every 108 ms while
// tx_repeat is held. ir_env is the unmodulated envelope, ir_tx the optionally
// carrier-modulated and inverted LED drive, both registered on the same edge.
module ir_xmit import ir_nec_pkg::*; #(
    parameter int unsigned UNIT_CYCLES = DEF_UNIT_CYCLES,
    parameter int unsigned CARR_PERIOD = DEF_CARR_PERIOD,
    parameter int unsigned CARR_HIGH   = DEF_CARR_HIGH,
    parameter bit          CARRIER_EN  = 1'b1,
    parameter bit          OUT_INV     = 1'b0
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic [15:0] tx_code,
    input  logic        tx_start,
    input  logic        tx_repeat,
    output logic        ir_tx,
    output logic        ir_env,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    ir_state_e      state_r;
    logic [UW-1:0]  unit_ctr_r;
    logic [4:0]     dur_ctr_r;
    logic [7:0]     per_ctr_r;
    logic [4:0]     bit_idx_r;
    logic [31:0]    shreg_r;
    logic           ir_env_r;
    logic           ir_tx_r;
    logic           busy_r;
    logic [7:0]     frame_cnt_r;

    logic           unit_tick_s;
    logic           unit_done_s;
    logic           mark_end_s;
    logic           gap_end_s;
    logic           carr_run_s;
    logic           carr_nxt_s;
    logic           tx_mark_s;

    assign unit_tick_s = (state_r != ST_IDLE) && (unit_ctr_r == UW'(UNIT_CYCLES - 1));
    assign unit_done_s = unit_tick_s && (dur_ctr_r == 5'd1);
    assign mark_end_s  = is_mark(state_r) && unit_done_s;
    assign gap_end_s   = (state_r == ST_GAP) && unit_tick_s && (per_ctr_r == (PERIOD_U - 8'd1));

    // The carrier keeps running only while the current mark continues
    assign carr_run_s = ir_env_r && !mark_end_s;

    // LED drive level for a cycle inside a mark
    assign tx_mark_s = OUT_INV ^ (CARRIER_EN ? carr_nxt_s : 1'b1);

    ir_carrier_gen #(
        .CARR_PERIOD (CARR_PERIOD),
        .CARR_HIGH   (CARR_HIGH)
    ) u_carrier (
        .clk27    (clk27),
        .reset_n  (reset_n),
        .run      (carr_run_s),
        .carr_nxt (carr_nxt_s)
    );

    // Frame sequencer with unit timing, shift register and registered outputs
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            unit_ctr_r  <= {UW{1'b0}};
            dur_ctr_r   <= 5'd0;
            per_ctr_r   <= 8'd0;
            bit_idx_r   <= 5'd0;
            shreg_r     <= 32'd0;
            ir_env_r    <= 1'b0;
            ir_tx_r     <= OUT_INV;
            busy_r      <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            // Unit timebase; transitions below override the counters they reload
            if (state_r != ST_IDLE) begin
                if (unit_tick_s) begin
                    unit_ctr_r <= {UW{1'b0}};
                end else begin
                    unit_ctr_r <= unit_ctr_r + UW'(1);
                end
                if (unit_tick_s && (per_ctr_r != PERIOD_U)) begin
                    per_ctr_r <= per_ctr_r + 8'd1;
                end
                if (unit_tick_s && (dur_ctr_r != 5'd0)) begin
                    dur_ctr_r <= dur_ctr_r - 5'd1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (tx_start) begin
                        state_r    <= ST_LEAD_MARK;
                        unit_ctr_r <= {UW{1'b0}};
                        per_ctr_r  <= 8'd0;
                        dur_ctr_r  <= LEAD_MARK_U;
                        bit_idx_r  <= 5'd0;
                        shreg_r    <= {~tx_code[7:0], tx_code[7:0], ~tx_code[15:8], tx_code[15:8]};
                        ir_env_r   <= 1'b1;
                        ir_tx_r    <= tx_mark_s;
                        busy_r     <= 1'b1;
                    end
                end
                ST_LEAD_MARK: begin
                    if (unit_done_s) begin
                        state_r   <= ST_LEAD_SPACE;
                        dur_ctr_r <= LEAD_SPACE_U;
                        ir_env_r  <= 1'b0;
                        ir_tx_r   <= OUT_INV;
                    end else begin
                        ir_tx_r   <= tx_mark_s;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (unit_done_s) begin
                        state_r   <= ST_BIT_MARK;
                        dur_ctr_r <= BIT_U;
                        ir_env_r  <= 1'b1;
                        ir_tx_r   <= tx_mark_s;
                    end
                end
                ST_BIT_MARK: begin
                    if (unit_done_s) begin
                        state_r   <= ST_BIT_SPACE;
                        dur_ctr_r <= shreg_r[0] ? ONE_SPACE_U : BIT_U;
                        ir_env_r  <= 1'b0;
                        ir_tx_r   <= OUT_INV;
                    end else begin
                        ir_tx_r   <= tx_mark_s;
                    end
                end
                ST_BIT_SPACE: begin
                    if (unit_done_s) begin
                        shreg_r   <= shreg_r >> 1;
                        dur_ctr_r <= BIT_U;
                        ir_env_r  <= 1'b1;
                        ir_tx_r   <= tx_mark_s;
                        if (bit_idx_r == 5'd31) begin
                            state_r   <= ST_STOP_MARK;
                        end else begin
                            state_r   <= ST_BIT_MARK;
                            bit_idx_r <= bit_idx_r + 5'd1;
                        end
                    end
                end
                ST_STOP_MARK, ST_REP_STOP: begin
                    if (unit_done_s) begin
                        state_r     <= ST_GAP;
                        dur_ctr_r   <= 5'd0;
                        ir_env_r    <= 1'b0;
                        ir_tx_r     <= OUT_INV;
                        frame_cnt_r <= frame_cnt_r + 8'd1;
                    end else begin
                        ir_tx_r     <= tx_mark_s;
                    end
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        if (tx_repeat) begin
                            state_r   <= ST_REP_MARK;
                            per_ctr_r <= 8'd0;
                            dur_ctr_r <= LEAD_MARK_U;
                            ir_env_r  <= 1'b1;
                            ir_tx_r   <= tx_mark_s;
                        end else begin
                            state_r   <= ST_IDLE;
                            per_ctr_r <= 8'd0;
                            bit_idx_r <= 5'd0;
                            busy_r    <= 1'b0;
                        end
                    end
                end
                ST_REP_MARK: begin
                    if (unit_done_s) begin
                        state_r   <= ST_REP_SPACE;
                        dur_ctr_r <= REP_SPACE_U;
                        ir_env_r  <= 1'b0;
                        ir_tx_r   <= OUT_INV;
                    end else begin
                        ir_tx_r   <= tx_mark_s;
                    end
                end
                ST_REP_SPACE: begin
                    if (unit_done_s) begin
                        state_r   <= ST_REP_STOP;
                        dur_ctr_r <= BIT_U;
                        ir_env_r  <= 1'b1;
                        ir_tx_r   <= tx_mark_s;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    unit_ctr_r <= {UW{1'b0}};
                    dur_ctr_r  <= 5'd0;
                    per_ctr_r  <= 8'd0;
                    bit_idx_r  <= 5'd0;
                    ir_env_r   <= 1'b0;
                    ir_tx_r    <= OUT_INV;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign ir_tx     = ir_tx_r;
    assign ir_env    = ir_env_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_ir_xmit.sv
// Directed bench for ir_xmit with a shortened timebase: 4 cycles per NEC unit
// and a 3-cycle carrier (1 cycle high). A full frame period is 192*4 = 768
// cycles; leader 64/32, bit mark 4, zero space 4, one space 12, repeat space 16.
module tb_ir_xmit;

    localparam int UC = 4;
    localparam int CP = 3;
    localparam int CH = 1;
    localparam int FRAME_CYC = 192 * UC;

    logic        clk27;
    logic        reset_n;
    logic [15:0] tx_code;
    logic        tx_start;
    logic        tx_repeat;
    logic        ir_tx;
    logic        ir_env;
    logic        busy;
    logic [7:0]  frame_cnt;

    int checks   = 0;
    int failures = 0;
    int tx_err   = 0;
    int cyc      = 0;
    int c0       = 0;
    int n        = 0;
    logic [31:0] word;

    ir_xmit #(
        .UNIT_CYCLES (UC),
        .CARR_PERIOD (CP),
        .CARR_HIGH   (CH),
        .CARRIER_EN  (1'b1),
        .OUT_INV     (1'b0)
    ) dut (
        .clk27     (clk27),
        .reset_n   (reset_n),
        .tx_code   (tx_code),
        .tx_start  (tx_start),
        .tx_repeat (tx_repeat),
        .ir_tx     (ir_tx),
        .ir_env    (ir_env),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk27 = 1'b0;
    always #5 clk27 = ~clk27;

    // Free-running edge counter used for frame-period timing
    always @(posedge clk27) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts cycles while ir_env holds lvl, checking the carrier on ir_tx
    task automatic count_level(input logic lvl, output int len);
        logic exp_tx;
        len = 0;
        while (ir_env === lvl && len < 4000) begin
            exp_tx = lvl & ((len % CP) < CH);
            if (ir_tx !== exp_tx) tx_err++;
            len++;
            @(negedge clk27);
        end
    endtask

    // Measures one full frame from the first leader cycle through the stop mark;
    // optionally fires a competing tx_start during the first bit space
    task automatic decode_frame(input bit inject, output logic [31:0] w);
        int m;
        int s;
        int bad;
        bad = 0;
        w = 32'd0;
        count_level(1'b1, m);
        chk("lead_mark_len", m, 64);
        count_level(1'b0, s);
        chk("lead_space_len", s, 32);
        for (int i = 0; i < 32; i++) begin
            count_level(1'b1, m);
            if (m != 4) bad++;
            if (inject && i == 0) begin
                tx_code  = 16'h1234;
                tx_start = 1'b1;
            end
            count_level(1'b0, s);
            if (inject && i == 0) tx_start = 1'b0;
            if (s == 12) w[i] = 1'b1;
            else if (s != 4) bad++;
        end
        chk("bit_timing_errors", bad, 0);
        count_level(1'b1, m);
        chk("stop_mark_len", m, 4);
    endtask

    task automatic wait_busy_low();
        while (busy === 1'b1 && cyc < c0 + 5000) @(negedge clk27);
    endtask

    initial begin
        reset_n   = 1'b0;
        tx_code   = 16'h0000;
        tx_start  = 1'b0;
        tx_repeat = 1'b0;
        repeat (3) @(negedge clk27);
        chk("rst_env", ir_env, 1'b0);
        chk("rst_tx", ir_tx, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 8'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk27);
        chk("idle_busy", busy, 1'b0);

        // Full frame 0x20DF
        tx_code  = 16'h20DF;
        tx_start = 1'b1;
        @(negedge clk27);
        tx_start = 1'b0;
        c0 = cyc;
        chk("start_env", ir_env, 1'b1);
        chk("start_tx", ir_tx, 1'b1);
        chk("start_busy", busy, 1'b1);
        decode_frame(1'b0, word);
        chk("frame1_bits", word, 32'h20DF_DF20);
        chk("frame1_cnt", frame_cnt, 8'd1);
        chk("gap_busy", busy, 1'b1);
        wait_busy_low();
        chk("frame1_busy_fall", cyc - c0, FRAME_CYC);

        // Start with repeat already high: full frame, then three repeat frames
        tx_repeat = 1'b1;
        tx_code   = 16'h00FF;
        tx_start  = 1'b1;
        @(negedge clk27);
        tx_start = 1'b0;
        c0 = cyc;
        decode_frame(1'b0, word);
        chk("frame2_bits", word, 32'h00FF_FF00);
        chk("frame2_cnt", frame_cnt, 8'd2);
        for (int r = 1; r <= 3; r++) begin
            while (cyc < c0 + FRAME_CYC * r) @(negedge clk27);
            chk("rep_start_env", ir_env, 1'b1);
            count_level(1'b1, n);
            chk("rep_mark_len", n, 64);
            count_level(1'b0, n);
            chk("rep_space_len", n, 16);
            count_level(1'b1, n);
            chk("rep_stop_len", n, 4);
            chk("rep_frame_cnt", frame_cnt, 8'(2 + r));
            if (r == 3) tx_repeat = 1'b0;
        end
        while (cyc < c0 + 4 * FRAME_CYC - 1) @(negedge clk27);
        chk("rep_busy_hold", busy, 1'b1);
        @(negedge clk27);
        chk("rep_busy_fall", busy, 1'b0);

        // A start request during the frame must be ignored, not queued
        tx_code  = 16'h20DF;
        tx_start = 1'b1;
        @(negedge clk27);
        tx_start = 1'b0;
        c0 = cyc;
        decode_frame(1'b1, word);
        chk("ignored_start_bits", word, 32'h20DF_DF20);
        chk("ignored_start_cnt", frame_cnt, 8'd6);
        wait_busy_low();
        chk("ignored_busy_fall", cyc - c0, FRAME_CYC);
        repeat (20) @(negedge clk27);
        chk("no_queued_env", ir_env, 1'b0);
        chk("no_queued_busy", busy, 1'b0);

        // Asynchronous reset in the middle of the leader
        tx_start = 1'b1;
        @(negedge clk27);
        tx_start = 1'b0;
        repeat (10) @(negedge clk27);
        chk("pre_reset_env", ir_env, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_env", ir_env, 1'b0);
        chk("async_rst_tx", ir_tx, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_cnt", frame_cnt, 8'd0);
        @(negedge clk27);
        reset_n = 1'b1;
        @(negedge clk27);
        tx_code  = 16'h20DF;
        tx_start = 1'b1;
        @(negedge clk27);
        tx_start = 1'b0;
        c0 = cyc;
        decode_frame(1'b0, word);
        chk("post_reset_bits", word, 32'h20DF_DF20);
        chk("post_reset_cnt", frame_cnt, 8'd1);
        chk("carrier_errors", tx_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
